// File: rtl/pe_incha_single_core_pkg.sv
// Shared constants and helpers for the single-window convolution PE.
// Holds weight-port address types, Q8.8 constants and the output-width rule.
package pe_incha_single_core_pkg;

  localparam logic [7:0] ADDR_KERNEL = 8'h00;
  localparam logic [7:0] ADDR_BIAS   = 8'h01;
  localparam logic [7:0] ADDR_COEFF  = 8'h02;

  localparam int          Q_SHIFT   = 8;
  localparam int          Q_ROUND   = 1 << (Q_SHIFT - 1);
  localparam logic [15:0] COEFF_ONE = 16'h0100;
  localparam int          PROD_W    = 40;

  typedef enum logic [1:0] {
    PE_IDLE    = 2'd0,
    PE_COMPUTE = 2'd1,
    PE_DONE    = 2'd2
  } pe_state_t;

  // relu results fit a byte; linear results keep a 16-bit signed range
  function automatic int out_width(input bit relu);
    return relu ? 8 : 16;
  endfunction

endpackage

// File: rtl/pe_incha_single_core_weight_ram.sv
// Small write-through register RAM with lane-granular writes and async read.
// Used for both the per-channel kernel rows and the bias words.
module pe_weight_ram #(
  parameter int  DEPTH  = 4,
  parameter int  WIDTH  = 8,
  parameter int  LANE_W = 8,
  localparam int LANES  = WIDTH / LANE_W,
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LW     = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [LW-1:0]     wlane,
  input  logic [LANE_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr][wlane*LANE_W +: LANE_W] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pe_incha_single_core.sv
// Convolution PE: latches one window, computes one channel dot product per cycle,
// then requantizes, adds bias, rounds and clamps into a held output buffer.
//   state      | meaning
//   PE_IDLE    | ready for a window
//   PE_COMPUTE | issuing dot products, post-process stage draining behind
//   PE_DONE    | o_data complete, o_valid high
module pe_incha_single_core
  import pe_incha_single_core_pkg::*;
#(
  parameter int    IN_WIDTH    = 3,
  parameter int    IN_HEIGHT   = 3,
  parameter int    IN_CHANNEL  = 2,
  parameter int    OUT_CHANNEL = 4,
  parameter int    KERNEL_0    = 3,
  parameter int    KERNEL_1    = 3,
  parameter int    DILATION_0  = 1,
  parameter int    DILATION_1  = 1,
  parameter int    PADDING_0   = 1,
  parameter int    PADDING_1   = 1,
  parameter int    STRIDE_0    = 1,
  parameter int    STRIDE_1    = 1,
  parameter string OUTPUT_MODE = "relu",
  localparam int   KERNEL_PTS  = KERNEL_0 * KERNEL_1,
  localparam int   N           = IN_CHANNEL * KERNEL_PTS,
  localparam bit   RELU        = (OUTPUT_MODE == "relu"),
  localparam int   OW          = out_width(RELU)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [8*N-1:0]            i_data,
  input  logic                      i_valid,
  output logic                      pe_ready,
  output logic                      pe_ack,
  output logic [OW*OUT_CHANNEL-1:0] o_data,
  output logic                      o_valid,
  input  logic                      weight_wr_en,
  input  logic [31:0]               weight_wr_addr,
  input  logic [15:0]               weight_wr_data
);

  localparam int AW    = (OUT_CHANNEL > 1) ? $clog2(OUT_CHANNEL) : 1;
  localparam int CW    = $clog2(OUT_CHANNEL + 1);
  localparam int NL    = (N > 1) ? $clog2(N) : 1;
  localparam int ACC_W = (16 + $clog2(N) > 24) ? 16 + $clog2(N) : 24;
  localparam logic [CW-1:0] LAST_CH = CW'(OUT_CHANNEL - 1);

  localparam logic signed [PROD_W-1:0] RELU_MAX = 40'sd127;
  localparam logic signed [PROD_W-1:0] LIN_MAX  = 40'sd32767;
  localparam logic signed [PROD_W-1:0] LIN_MIN  = -40'sd32768;

  localparam int unused_geom = IN_WIDTH + IN_HEIGHT + DILATION_0 + DILATION_1 +
                               PADDING_0 + PADDING_1 + STRIDE_0 + STRIDE_1;

  pe_state_t state, state_nxt;

  logic [8*N-1:0]           win;
  logic [CW-1:0]            kernel_cnt, bias_cnt;
  logic                     post_valid, ack_q, accept, feeding;
  logic [15:0]              coeff;
  logic [8*N-1:0]           kernel_row;
  logic [15:0]              bias_word;
  logic signed [15:0]       prods [N];
  logic signed [ACC_W-1:0]  dot, acc_q;
  logic signed [PROD_W-1:0] prod, sum, r;
  logic [OW-1:0]            post_val;
  logic [OW*OUT_CHANNEL-1:0] obuf, obuf_nxt;

  logic [7:0] wr_type, wr_oc, wr_pos;
  logic       wr_ok, kernel_we, bias_we, coeff_we;
  logic       unused_addr;

  assign wr_type     = weight_wr_addr[31:24];
  assign wr_oc       = weight_wr_addr[23:16];
  assign wr_pos      = weight_wr_addr[15:8];
  assign unused_addr = ^weight_wr_addr[7:0];
  assign wr_ok       = weight_wr_en && (int'(wr_oc) < OUT_CHANNEL) && (int'(wr_pos) < N);
  assign kernel_we   = wr_ok && (wr_type == ADDR_KERNEL);
  assign bias_we     = wr_ok && (wr_type == ADDR_BIAS);
  assign coeff_we    = wr_ok && (wr_type == ADDR_COEFF);

  pe_weight_ram #(.DEPTH(OUT_CHANNEL), .WIDTH(8*N), .LANE_W(8)) u_kernel (
    .clk   (clk),
    .we    (kernel_we),
    .waddr (wr_oc[AW-1:0]),
    .wlane (wr_pos[NL-1:0]),
    .wdata (weight_wr_data[7:0]),
    .raddr (kernel_cnt[AW-1:0]),
    .rdata (kernel_row)
  );

  pe_weight_ram #(.DEPTH(OUT_CHANNEL), .WIDTH(16), .LANE_W(16)) u_bias (
    .clk   (clk),
    .we    (bias_we),
    .waddr (wr_oc[AW-1:0]),
    .wlane (1'b0),
    .wdata (weight_wr_data),
    .raddr (bias_cnt[AW-1:0]),
    .rdata (bias_word)
  );

  assign pe_ready = (state == PE_IDLE);
  assign o_valid  = (state == PE_DONE);
  assign pe_ack   = ack_q;
  assign accept   = pe_ready && i_valid;
  assign feeding  = (state == PE_COMPUTE) && (kernel_cnt < CW'(OUT_CHANNEL));

  always_comb begin
    state_nxt = state;
    case (state)
      PE_IDLE:    if (i_valid) state_nxt = PE_COMPUTE;
      PE_COMPUTE: if (post_valid && (bias_cnt == LAST_CH)) state_nxt = PE_DONE;
      PE_DONE:    state_nxt = PE_IDLE;
      default:    state_nxt = PE_IDLE;
    endcase
  end

  for (genvar i = 0; i < N; i++) begin : g_mul
    assign prods[i] = 16'(signed'(win[8*i +: 8])) * 16'(signed'(kernel_row[8*i +: 8]));
  end

  always_comb begin
    dot = '0;
    for (int i = 0; i < N; i++) dot = dot + ACC_W'(prods[i]);
  end

  always_comb begin
    prod = PROD_W'(acc_q) * signed'(PROD_W'(coeff));
    sum  = prod + (PROD_W'(signed'(bias_word)) <<< Q_SHIFT);
    r    = (sum + PROD_W'(Q_ROUND)) >>> Q_SHIFT;
    if (RELU) begin
      if (r < 0)             post_val = '0;
      else if (r > RELU_MAX) post_val = OW'(RELU_MAX);
      else                   post_val = OW'(r);
    end else begin
      if (r > LIN_MAX)       post_val = OW'(LIN_MAX);
      else if (r < LIN_MIN)  post_val = OW'(LIN_MIN);
      else                   post_val = OW'(r);
    end
    obuf_nxt = obuf;
    obuf_nxt[OW*bias_cnt[AW-1:0] +: OW] = post_val;
  end

  // o_data is loaded only with the last channel so it holds across the next window
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= PE_IDLE;
      ack_q      <= 1'b0;
      win        <= '0;
      kernel_cnt <= '0;
      bias_cnt   <= '0;
      post_valid <= 1'b0;
      acc_q      <= '0;
      obuf       <= '0;
      o_data     <= '0;
      coeff      <= COEFF_ONE;
    end else begin
      state      <= state_nxt;
      ack_q      <= accept;
      post_valid <= feeding;
      bias_cnt   <= kernel_cnt;
      acc_q      <= dot;
      if (accept) begin
        win        <= i_data;
        kernel_cnt <= '0;
      end else if (feeding) begin
        kernel_cnt <= kernel_cnt + CW'(1);
      end
      if (post_valid) begin
        obuf <= obuf_nxt;
        if (bias_cnt == LAST_CH) o_data <= obuf_nxt;
      end
      if (coeff_we) coeff <= weight_wr_data;
    end
  end

endmodule

// File: tb/tb_pe_incha_single_core.sv
// Scoreboard bench: relu and linear instances share stimulus; expectations come
// from literal test-plan values or a plain-arithmetic model of the PE.
module tb_pe_incha_single_core;

  localparam int OC = 4;
  localparam int NP = 18;

  logic         clk = 1'b0;
  logic         rst;
  logic [8*NP-1:0] i_data;
  logic         i_valid;
  logic         weight_wr_en;
  logic [31:0]  weight_wr_addr;
  logic [15:0]  weight_wr_data;

  logic         pe_ready_r, pe_ack_r, o_valid_r;
  logic [31:0]  o_data_r;
  logic         pe_ready_l, pe_ack_l, o_valid_l;
  logic [63:0]  o_data_l;

  always #5 clk = ~clk;

  pe_incha_single_core dut_relu (
    .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid),
    .pe_ready(pe_ready_r), .pe_ack(pe_ack_r), .o_data(o_data_r), .o_valid(o_valid_r),
    .weight_wr_en(weight_wr_en), .weight_wr_addr(weight_wr_addr), .weight_wr_data(weight_wr_data)
  );

  pe_incha_single_core #(.OUTPUT_MODE("linear")) dut_lin (
    .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid),
    .pe_ready(pe_ready_l), .pe_ack(pe_ack_l), .o_data(o_data_l), .o_valid(o_valid_l),
    .weight_wr_en(weight_wr_en), .weight_wr_addr(weight_wr_addr), .weight_wr_data(weight_wr_data)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int w_m [OC][NP];
  int b_m [OC];
  int coeff_m;
  int xm [NP];
  int er [OC];
  int el [OC];

  logic [31:0] q_relu [$];
  logic [63:0] q_lin  [$];
  logic [31:0] ev_r;
  logic [63:0] ev_l;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint model_r(input int k);
    longint acc = 0;
    longint s;
    for (int i = 0; i < NP; i++) acc += longint'(xm[i]) * longint'(w_m[k][i]);
    s = acc * longint'(coeff_m) + longint'(b_m[k]) * 256 + 128;
    return s >>> 8;
  endfunction

  function automatic int relu_of(input longint v);
    return (v < 0) ? 0 : (v > 127) ? 127 : int'(v);
  endfunction

  function automatic int lin_of(input longint v);
    return (v > 32767) ? 32767 : (v < -32768) ? -32768 : int'(v);
  endfunction

  always @(negedge clk) begin
    if (!rst && o_valid_r) begin
      if (q_relu.size() == 0) check("relu_unexpected_valid", o_valid_r, 0);
      else begin
        ev_r = q_relu.pop_front();
        for (int k = 0; k < OC; k++)
          check($sformatf("relu_ch%0d", k), longint'(signed'(o_data_r[8*k +: 8])),
                longint'(signed'(ev_r[8*k +: 8])));
      end
    end
    if (!rst && o_valid_l) begin
      if (q_lin.size() == 0) check("lin_unexpected_valid", o_valid_l, 0);
      else begin
        ev_l = q_lin.pop_front();
        for (int k = 0; k < OC; k++)
          check($sformatf("lin_ch%0d", k), longint'(signed'(o_data_l[16*k +: 16])),
                longint'(signed'(ev_l[16*k +: 16])));
      end
    end
  end

  task automatic wr(input logic [7:0] typ, input logic [7:0] oc, input logic [7:0] pos,
                    input logic [15:0] d);
    weight_wr_en   = 1'b1;
    weight_wr_addr = {typ, oc, pos, 8'h00};
    weight_wr_data = d;
    @(negedge clk);
    weight_wr_en = 1'b0;
    if (typ <= 8'd2 && int'(oc) < OC && int'(pos) < NP) begin
      case (typ)
        8'd0:    w_m[oc][pos] = int'(signed'(d[7:0]));
        8'd1:    b_m[oc] = int'(signed'(d));
        default: coeff_m = int'(d);
      endcase
    end
  endtask

  task automatic load_plan();
    int bp [OC];
    bp = '{10, 20, -30, 40};
    for (int k = 0; k < OC; k++)
      for (int p = 0; p < NP; p++) wr(8'd0, 8'(k), 8'(p), 16'(k + 1));
    for (int k = 0; k < OC; k++) wr(8'd1, 8'(k), 8'd0, 16'(bp[k]));
    wr(8'd2, 8'd0, 8'd0, 16'h0100);
  endtask

  task automatic apply_window();
    logic [31:0] vr;
    logic [63:0] vl;
    int n;
    for (int k = 0; k < OC; k++) begin
      vr[8*k +: 8]   = 8'(er[k]);
      vl[16*k +: 16] = 16'(el[k]);
    end
    for (int i = 0; i < NP; i++) i_data[8*i +: 8] = 8'(xm[i]);
    i_valid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!pe_ack_r && n < 20);
    i_valid = 1'b0;
    check("ack_seen", pe_ack_r, 1);
    if (!pe_ack_r) return;
    q_relu.push_back(vr);
    q_lin.push_back(vl);
    check("ready_low_at_ack", pe_ready_r, 0);
    n = 0;
    do begin @(negedge clk); n++; end while (!o_valid_r && n < 20);
    check("ack_to_valid_gap", n, OC + 1);
    @(negedge clk);
    check("ready_after_valid", pe_ready_r, 1);
    check("valid_single_pulse", o_valid_r, 0);
    check("o_data_hold_relu", longint'(o_data_r), longint'(vr));
    check("o_data_hold_lin", longint'(o_data_l), longint'(vl));
  endtask

  task automatic model_expect();
    for (int k = 0; k < OC; k++) begin
      er[k] = relu_of(model_r(k));
      el[k] = lin_of(model_r(k));
    end
  endtask

  initial begin
    int cnt;
    rst = 1'b1; i_valid = 1'b0; i_data = '0;
    weight_wr_en = 1'b0; weight_wr_addr = '0; weight_wr_data = '0;
    coeff_m = 256;
    for (int k = 0; k < OC; k++) begin
      b_m[k] = 0;
      for (int p = 0; p < NP; p++) w_m[k][p] = 0;
    end
    repeat (3) @(negedge clk);
    check("rst_pe_ready", pe_ready_r, 1);
    check("rst_pe_ack", pe_ack_r, 0);
    check("rst_o_valid", o_valid_r, 0);
    check("rst_o_data_relu", longint'(o_data_r), 0);
    check("rst_o_data_lin", longint'(o_data_l), 0);
    check("rst_pe_ready_lin", pe_ready_l, 1);
    rst = 1'b0;
    @(negedge clk);
    load_plan();

    for (int i = 0; i < NP; i++) xm[i] = 1;
    er = '{28, 56, 24, 112}; el = '{28, 56, 24, 112};
    apply_window();

    for (int i = 0; i < NP; i++) xm[i] = (i < 9) ? 1 : 2;
    er = '{37, 74, 51, 127}; el = '{37, 74, 51, 148};
    apply_window();

    for (int i = 0; i < NP; i++) xm[i] = i + 1;
    er = '{127, 127, 127, 127}; el = '{181, 362, 483, 724};
    apply_window();

    wr(8'd2, 8'd0, 8'd0, 16'h0200);
    for (int i = 0; i < NP; i++) xm[i] = 1;
    er = '{46, 92, 78, 127}; el = '{46, 92, 78, 184};
    apply_window();
    wr(8'd2, 8'd0, 8'd0, 16'h0100);

    for (int i = 0; i < NP; i++) xm[i] = -1;
    er = '{0, 0, 0, 0}; el = '{-8, -16, -84, -32};
    apply_window();

    for (int round = 0; round < 6; round++) begin
      for (int k = 0; k < OC; k++)
        for (int p = 0; p < NP; p++) wr(8'd0, 8'(k), 8'(p), 16'($urandom_range(0, 255)));
      for (int k = 0; k < OC; k++) wr(8'd1, 8'(k), 8'd0, 16'($urandom));
      wr(8'd2, 8'd0, 8'd0, (round % 2 == 1) ? 16'($urandom) : 16'($urandom_range(0, 512)));
      for (int w = 0; w < 4; w++) begin
        for (int i = 0; i < NP; i++) xm[i] = int'($urandom_range(0, 255)) - 128;
        model_expect();
        apply_window();
      end
    end

    load_plan();

    for (int i = 0; i < NP; i++) i_data[8*i +: 8] = 8'd1;
    i_valid = 1'b1;
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (!pe_ack_r && cnt < 20);
    i_valid = 1'b0;
    check("abort_ack_seen", pe_ack_r, 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("ready_after_abort_reset", pe_ready_r, 1);
    check("valid_low_after_abort_reset", o_valid_r, 0);
    rst = 1'b0;
    coeff_m = 256;
    cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (o_valid_r || o_valid_l) cnt++;
    end
    check("aborted_no_valid", cnt, 0);

    wr(8'd0, 8'd4,   8'd0,  16'h007F);
    wr(8'd0, 8'd255, 8'd3,  16'h007F);
    wr(8'd0, 8'd0,   8'd18, 16'h007F);
    wr(8'd3, 8'd0,   8'd0,  16'h007F);
    wr(8'hFF, 8'd1,  8'd1,  16'h007F);
    wr(8'd1, 8'd4,   8'd0,  16'h1000);
    wr(8'd1, 8'd0,   8'd200, 16'h1000);
    for (int i = 0; i < NP; i++) xm[i] = 1;
    er = '{28, 56, 24, 112}; el = '{28, 56, 24, 112};
    apply_window();

    repeat (3) @(negedge clk);
    check("scoreboard_drained_relu", q_relu.size(), 0);
    check("scoreboard_drained_lin", q_lin.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    n_bad++;
    $display("FAIL global_timeout: got running expected finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
